central_fsm: RTL and testbench
==============================

CENTRAL_FSM -- requirements
Module: central_fsm

Interface
REQ-001 Parameter OP_W, default 3, SHALL be the opcode width (>=3); bits above [2:0] must be zero for a legal opcode.
REQ-002 Parameter TIMEOUT, default 16, SHALL be the maximum number of memory wait cycles; 0 disables the timeout.
REQ-003 Parameter CNT_W, default 16, SHALL be the retired-instruction counter width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 clr  input  1  SHALL be the synchronous, active-high reset.
REQ-006 op  input  OP_W  SHALL be the instruction opcode, sampled only in DECODE.
REQ-007 mem_ready  input  1  SHALL be the memory handshake acknowledge, sampled in FETCH and MEM.
REQ-008 mux_sum  output  2  SHALL be the ALU operation select.
REQ-009 mux_y  output  1  SHALL be the register write-back source select (0 = ALU, 1 = memory).
REQ-010 we  output  1  SHALL be the register-file write enable.
REQ-011 en_fetch  output  1  SHALL be the instruction-fetch enable.
REQ-012 r  output  1  SHALL be the memory read request.
REQ-013 mem_wr  output  1  SHALL be the memory write request.
REQ-014 state  output  3  SHALL be the current state encoding.
REQ-015 halted, illegal, timeout  output  1 each  SHALL be the sticky status flags.
REQ-016 retired  output  CNT_W  SHALL be the count of completed instructions.

Function
REQ-017 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to HALT on the next edge.
REQ-018 Outputs mux_sum, mux_y, we, en_fetch, r and mem_wr SHALL be decoded only from the state register and the latched opcode op_q (Moore style), with no combinational path from op or mem_ready.
REQ-019 Opcodes [2:0]: 000 ADD, 001 SUB, 010 LOAD, 011 STORE, 100 MOVY, 101 NOP, 111 HALT; 110, or any nonzero upper bit, SHALL be illegal.
REQ-020 FETCH: en_fetch=1, r=1; go to DECODE when mem_ready=1, otherwise stay.
REQ-021 DECODE: latch op into op_q; go to HALT with illegal=1 if op is illegal, otherwise go to EXEC.
REQ-022 EXEC: mux_sum = 00 (ADD), 01 (SUB), 10 (LOAD/STORE address), 11 (MOVY), 00 (otherwise).
REQ-023 EXEC next state: ADD, SUB and MOVY go to WB; LOAD and STORE go to MEM; NOP goes to FETCH; HALT goes to HALT with halted=1.
REQ-024 MEM: r=1 for LOAD and mem_wr=1 for STORE; on mem_ready=1, LOAD goes to WB and STORE goes to FETCH.
REQ-025 WB: we=1, mux_y=1 only for LOAD, and mux_sum holds the EXEC value; always go to FETCH.
REQ-026 All control outputs SHALL be 0 in states other than those listed above; in HALT all are 0.
REQ-027 retired SHALL increment by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from EXEC, MEM or WB; HALT and illegal opcodes SHALL not count.
REQ-028 Wait counter: clear on entry to FETCH or MEM; increment each cycle that state is FETCH or MEM with mem_ready=0.
REQ-029 Timeout: when the wait counter equals TIMEOUT-1 and mem_ready=0 (TIMEOUT>0), go to HALT with timeout=1.
REQ-030 If mem_ready=1 in the same cycle as the timeout limit, the handshake SHALL win and no timeout is flagged.
REQ-031 HALT SHALL be absorbing until clr; halted=1 in HALT regardless of cause; illegal and timeout SHALL identify the cause.

Reset
REQ-032 clr=1 at a clock edge SHALL set state=FETCH, op_q=0, wait counter=0, retired=0, and halted, illegal and timeout to 0, overriding any state including mid-MEM.
REQ-033 Immediately after reset, outputs SHALL be en_fetch=1, r=1, and mux_sum=00, mux_y=0, we=0, mem_wr=0.

Verification
REQ-034 ADD with mem_ready=1: states FETCH, DECODE, EXEC (mux_sum=00), WB (we=1, mux_y=0), FETCH; retired 0->1 after 4 cycles.
REQ-035 LOAD with mem_ready low for 3 MEM cycles: MEM r=1 for 4 cycles, then WB with we=1, mux_y=1; retired +1.
REQ-036 STORE then NOP: mem_wr=1 only in MEM, no we pulse; NOP returns EXEC->FETCH; retired +2.
REQ-037 op=110, then separately op=1000 with OP_W=4: HALT with illegal=1 and halted=1; retired unchanged; stays in HALT for 10 cycles.
REQ-038 TIMEOUT=4 with mem_ready=0 in FETCH: HALT with timeout=1 after the 4th FETCH cycle; repeat with mem_ready=1 on the 4th cycle -> DECODE, timeout=0.
REQ-039 clr asserted in MEM, and retired wrap with CNT_W=2: reset values per REQ-032 the next cycle; 4 completions return retired to 0.

Source files
------------

// File: rtl/central_fsm.sv
// Multi-cycle CPU control FSM with memory handshake timeout,
// sticky halt/illegal/timeout status and a retired-instruction counter.
module central_fsm #(
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  output logic [1:0]       mux_sum,
  output logic             mux_y,
  output logic             we,
  output logic             en_fetch,
  output logic             r,
  output logic             mem_wr,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_MOVY  = 3'b100;
  localparam logic [2:0] OP_NOP   = 3'b101;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic             tmo_q, tmo_d;

  logic             op_legal;
  logic             tmo_hit;
  logic             in_wait;
  logic [1:0]       alu_sel;
  logic             is_load;
  logic             is_store;

  // op_q keeps only [2:0]: a latched opcode with upper bits set never leaves DECODE
  assign op_legal = ((op >> 3) == '0) && (op[2:0] != 3'b110);
  assign in_wait  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign tmo_hit  = (TIMEOUT > 0) && !mem_ready
                 && (wait_q == WW'(TIMEOUT - 1));

  assign is_load  = (op_q == OP_LOAD);
  assign is_store = (op_q == OP_STORE);

  always_comb begin
    alu_sel = 2'b00;
    unique case (1'b1)
      op_q == OP_SUB:          alu_sel = 2'b01;
      is_load, is_store:       alu_sel = 2'b10;
      op_q == OP_MOVY:         alu_sel = 2'b11;
      default:                 alu_sel = 2'b00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = wait_q;
    ret_d     = ret_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    tmo_d     = tmo_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_HALT;
          tmo_d   = 1'b1;
        end
      end
      S_DECODE: begin
        op_d = op[2:0];
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD, OP_SUB, OP_MOVY: state_d = S_WB;
          OP_LOAD, OP_STORE:       state_d = S_MEM;
          OP_NOP:                  state_d = S_FETCH;
          default:                 state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = is_load ? S_WB : S_FETCH;
        end else if (tmo_hit) begin
          state_d = S_HALT;
          tmo_d   = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    if (state_d == S_HALT) halted_d = 1'b1;

    if (state_d == S_FETCH &&
        (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
      ret_d = ret_q + 1'b1;

    if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q)
      wait_d = '0;
    else if (in_wait && !mem_ready)
      wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      wait_q    <= '0;
      ret_q     <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      ret_q     <= ret_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      tmo_q     <= tmo_d;
    end
  end

  // Moore decode: only state_q and op_q reach the control outputs
  always_comb begin
    mux_sum  = 2'b00;
    mux_y    = 1'b0;
    we       = 1'b0;
    en_fetch = 1'b0;
    r        = 1'b0;
    mem_wr   = 1'b0;
    unique case (1'b1)
      state_q == S_FETCH: begin
        en_fetch = 1'b1;
        r        = 1'b1;
      end
      state_q == S_EXEC: begin
        mux_sum = alu_sel;
      end
      state_q == S_MEM: begin
        r      = is_load;
        mem_wr = is_store;
      end
      state_q == S_WB: begin
        we      = 1'b1;
        mux_sum = alu_sel;
        mux_y   = is_load;
      end
      default: begin
        mux_sum = 2'b00;
      end
    endcase
  end

  assign state   = state_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign timeout = tmo_q;
  assign retired = ret_q;

endmodule

// File: tb/tb_central_fsm.sv
// Bench for central_fsm: per-instruction expected traces built from
// opcode and handshake delays, driven cycle by cycle and compared.
module tb_central_fsm;

  localparam int OP_W = 4;
  localparam int TMO  = 4;
  localparam int CW   = 2;

  logic            clk = 1'b0;
  logic            clr;
  logic [OP_W-1:0] op;
  logic            mem_ready;
  logic [1:0]      mux_sum;
  logic            mux_y, we, en_fetch, r, mem_wr;
  logic [2:0]      state;
  logic            halted, illegal, timeout;
  logic [CW-1:0]   retired;

  central_fsm #(.OP_W(OP_W), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .op(op), .mem_ready(mem_ready),
    .mux_sum(mux_sum), .mux_y(mux_y), .we(we),
    .en_fetch(en_fetch), .r(r), .mem_wr(mem_wr),
    .state(state), .halted(halted), .illegal(illegal),
    .timeout(timeout), .retired(retired)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [9:0]    exp_q[$];
  int            rdy_q[$];
  int            dec_idx;
  logic [CW-1:0] m_ret;
  bit            m_h, m_i, m_t;

  logic [9:0] obs;
  assign obs = {state, mux_sum, mux_y, we, en_fetch, r, mem_wr};

  function automatic logic [9:0] mk(int st, int ms, int my,
                                    int w, int ef, int rr, int mw);
    return {3'(st), 2'(ms), 1'(my), 1'(w), 1'(ef), 1'(rr), 1'(mw)};
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Expected per-cycle trace; rdy 2 = don't care (randomized)
  task automatic plan(input logic [OP_W-1:0] o, input int fd, input int md);
    int lo;
    bit bad;
    int ms;
    lo  = int'(o[2:0]);
    bad = ((o >> 3) != 0) || (lo == 6);
    ms  = (lo == 1) ? 1 : (lo == 2 || lo == 3) ? 2 : (lo == 4) ? 3 : 0;
    exp_q.delete();
    rdy_q.delete();
    dec_idx = -1;
    for (int i = 0; i <= fd; i++) begin
      if (i >= TMO) begin m_h = 1; m_t = 1; return; end
      exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0));
      rdy_q.push_back(i == fd ? 1 : 0);
    end
    dec_idx = exp_q.size();
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    rdy_q.push_back(2);
    if (bad) begin m_h = 1; m_i = 1; return; end
    exp_q.push_back(mk(2, ms, 0, 0, 0, 0, 0));
    rdy_q.push_back(2);
    if (lo == 7) begin m_h = 1; return; end
    if (lo == 5) begin m_ret++; return; end
    if (lo == 2 || lo == 3) begin
      for (int j = 0; j <= md; j++) begin
        if (j >= TMO) begin m_h = 1; m_t = 1; return; end
        exp_q.push_back(mk(3, 0, 0, 0, 0, lo == 2, lo == 3));
        rdy_q.push_back(j == md ? 1 : 0);
      end
      if (lo == 3) begin m_ret++; return; end
    end
    exp_q.push_back(mk(4, ms, lo == 2, 1, 0, 0, 0));
    rdy_q.push_back(2);
    m_ret++;
  endtask

  task automatic do_reset();
    clr       = 1'b1;
    mem_ready = 1'($urandom);
    op        = OP_W'($urandom);
    @(negedge clk);
    clr   = 1'b0;
    m_ret = '0;
    m_h   = 0;
    m_i   = 0;
    m_t   = 0;
    chk("rst_ctl", obs, mk(0, 0, 0, 0, 1, 1, 0));
    chk("rst_retired", retired, 0);
    chk("rst_flags", {halted, illegal, timeout}, 0);
  endtask

  task automatic run(input logic [OP_W-1:0] o, input int fd,
                     input int md, input int cut);
    plan(o, fd, md);
    foreach (exp_q[k]) begin
      if (k == cut) begin do_reset(); return; end
      mem_ready = (rdy_q[k] == 2) ? 1'($urandom) : 1'(rdy_q[k]);
      op        = (k == dec_idx) ? o : OP_W'($urandom);
      chk("ctl", obs, exp_q[k]);
      @(negedge clk);
    end
    chk("retired", retired, m_ret);
    chk("flags", {halted, illegal, timeout}, {m_h, m_i, m_t});
    if (m_h) begin
      for (int c = 0; c < 10; c++) begin
        mem_ready = 1'($urandom);
        op        = OP_W'($urandom);
        chk("halt_hold", obs, mk(5, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
      end
      chk("halt_flags", {halted, illegal, timeout}, {m_h, m_i, m_t});
      chk("halt_retired", retired, m_ret);
      do_reset();
    end
  endtask

  initial begin
    clr       = 1'b1;
    op        = '0;
    mem_ready = 1'b0;
    do_reset();
    run(4'b0000, 0, 0, -1);
    run(4'b0010, 0, 3, -1);
    run(4'b0011, 1, 0, -1);
    run(4'b0101, 0, 0, -1);
    run(4'b0100, 2, 0, -1);
    run(4'b0001, 0, 1, -1);
    run(4'b0010, 0, 2, 3);
    for (int n = 0; n < 4; n++) run(4'b0000, 0, 0, -1);
    run(4'b0110, 0, 0, -1);
    run(4'b1000, 0, 0, -1);
    run(4'b0111, 0, 0, -1);
    run(4'b0000, 4, 0, -1);
    run(4'b0000, 3, 0, -1);
    run(4'b0010, 0, 4, -1);
    run(4'b0011, 0, 3, -1);
    for (int n = 0; n < 80; n++) begin
      logic [OP_W-1:0] ro;
      int rf, rm;
      ro = ($urandom_range(0, 9) < 8) ? OP_W'($urandom_range(0, 5))
                                      : OP_W'($urandom);
      rf = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 5)
                                       : $urandom_range(0, 3);
      rm = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 5)
                                       : $urandom_range(0, 3);
      run(ro, rf, rm, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
